// File: rtl/move_cmd_gen.sv
// rtl/move_cmd_gen.sv - button synchroniser, debouncer and one-move-at-a-time direction arbiter
module move_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_right_n,
    input  logic       key_left_n,
    input  logic       key_up_n,
    input  logic       key_down_n,
    output logic       mov_right,
    output logic       mov_left,
    output logic       mov_up,
    output logic       mov_down,
    output logic       busy,
    output logic [7:0] move_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, RELEASE_WAIT} state_t;

    // Key index: 0 = right, 1 = left, 2 = up, 3 = down (also the priority order).
    logic [3:0]       raw_n;
    logic [3:0]       sync1_n;
    logic [3:0]       sync2_n;
    logic [3:0]       synced;
    logic [3:0]       stable;
    logic [CNT_W-1:0] cnt [4];

    state_t     state, state_next;
    logic [1:0] sel, sel_next;
    logic [3:0] mov, mov_next;
    logic       count_inc;

    assign raw_n  = {key_down_n, key_up_n, key_left_n, key_right_n};
    assign synced = ~sync2_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_n <= '1;
            sync2_n <= '1;
        end else begin
            sync1_n <= raw_n;
            sync2_n <= sync1_n;
        end
    end

    // A key must disagree with its stable value for DEBOUNCE_CYCLES straight edges to flip it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (synced[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= synced[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sel        <= 2'd0;
            mov        <= 4'd0;
            move_count <= 8'd0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
            mov   <= mov_next;
            if (count_inc) move_count <= move_count + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        mov_next   = 4'd0;
        count_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (|stable) begin
                    if (stable[0])      sel_next = 2'd0;
                    else if (stable[1]) sel_next = 2'd1;
                    else if (stable[2]) sel_next = 2'd2;
                    else                sel_next = 2'd3;
                    mov_next   = 4'b0001 << sel_next;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                mov_next = 4'b0001 << sel;
                if (!stable[sel]) begin
                    mov_next   = 4'd0;
                    count_inc  = 1'b1;
                    // Any other key still down must be fully released before a new move.
                    state_next = (|(stable & ~(4'b0001 << sel))) ? RELEASE_WAIT : IDLE;
                end
            end
            RELEASE_WAIT: begin
                if (stable == 4'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mov_right = mov[0];
    assign mov_left  = mov[1];
    assign mov_up    = mov[2];
    assign mov_down  = mov[3];
    assign busy      = (state != IDLE);

endmodule
